// File: rtl/regbank_dualrd.sv
// regbank_dualrd: parametrised register bank with one write port and two
// independent combinational read ports, per-entry valid bits, out-of-range
// write rejection and a one-entry-per-clock sequential clear engine.
// Optional build macro: REGBANK_WRITE_BYPASS_EN enables write-first forwarding
// of an accepted write onto a read port addressing the same entry.
module regbank_dualrd #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              valid_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              valid_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              wr_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    // True when the address selects an implemented entry.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_C);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  vld_r;
    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] count_nx_s;
    logic              busy_r;
    logic              wr_err_r;
    logic              wr_accept_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic              valid_a_s;
    logic              valid_b_s;

    // Writes land only while idle and only on implemented entries.
    assign wr_accept_s = we && (state_r == ST_IDLE) && in_range(waddr);

    // Clear-engine next state and sweep counter.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nx_s = ST_CLEAR;
                    count_nx_s = {ADDR_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (count_r == LAST_C) begin
                    state_nx_s = ST_IDLE;
                    count_nx_s = {ADDR_W{1'b0}};
                end else begin
                    count_nx_s = count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                count_nx_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM, counter and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            count_r  <= {ADDR_W{1'b0}};
            busy_r   <= 1'b0;
            wr_err_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            count_r  <= count_nx_s;
            busy_r   <= (state_nx_s == ST_CLEAR);
            wr_err_r <= we && !wr_accept_s;
        end
    end

    // Storage: the sweep owns the bank while clearing, otherwise accepted writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            vld_r <= {DEPTH{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            mem_r[count_r] <= {DATA_W{1'b0}};
            vld_r[count_r] <= 1'b0;
        end else if (wr_accept_s) begin
            mem_r[waddr] <= wdata;
            vld_r[waddr] <= 1'b1;
        end
    end

    // Combinational read ports; unimplemented addresses read as empty.
    always_comb begin
        rdata_a_s = {DATA_W{1'b0}};
        valid_a_s = 1'b0;
        rdata_b_s = {DATA_W{1'b0}};
        valid_b_s = 1'b0;
        if (in_range(raddr_a)) begin
            rdata_a_s = mem_r[raddr_a];
            valid_a_s = vld_r[raddr_a];
        end else begin
            rdata_a_s = {DATA_W{1'b0}};
            valid_a_s = 1'b0;
        end
        if (in_range(raddr_b)) begin
            rdata_b_s = mem_r[raddr_b];
            valid_b_s = vld_r[raddr_b];
        end else begin
            rdata_b_s = {DATA_W{1'b0}};
            valid_b_s = 1'b0;
        end
`ifdef REGBANK_WRITE_BYPASS_EN
        // Write-first forwarding; wr_accept_s already excludes rejected writes.
        if (wr_accept_s && (raddr_a == waddr)) begin
            rdata_a_s = wdata;
            valid_a_s = 1'b1;
        end else begin
            valid_a_s = valid_a_s;
        end
        if (wr_accept_s && (raddr_b == waddr)) begin
            rdata_b_s = wdata;
            valid_b_s = 1'b1;
        end else begin
            valid_b_s = valid_b_s;
        end
`endif
    end

    assign rdata_a = rdata_a_s;
    assign valid_a = valid_a_s;
    assign rdata_b = rdata_b_s;
    assign valid_b = valid_b_s;
    assign busy    = busy_r;
    assign wr_err  = wr_err_r;

endmodule

// File: tb/tb_regbank_dualrd.sv
// Directed self-checking bench for regbank_dualrd (default parameters).
module tb_regbank_dualrd;

    logic       clk;
    logic       reset;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raddr_a;
    logic [7:0] rdata_a;
    logic       valid_a;
    logic [3:0] raddr_b;
    logic [7:0] rdata_b;
    logic       valid_b;
    logic       clr_start;
    logic       busy;
    logic       wr_err;

    int checks_s;
    int failures_s;
    int busy_cnt_s;
    int guard_s;

    regbank_dualrd dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a),
        .valid_a   (valid_a),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b),
        .valid_b   (valid_b),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it disagrees.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            failures_s++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted-or-rejected write cycle.
    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        we    = 1'b1;
        waddr = addr;
        wdata = data;
        tick();
        we    = 1'b0;
    endtask

    // Advance one clock and count the cycles busy was seen high.
    task automatic step_busy();
        tick();
        if (busy) busy_cnt_s++;
    endtask

    initial begin
        checks_s   = 0;
        failures_s = 0;
        reset      = 1'b0;
        we         = 1'b0;
        waddr      = 4'd0;
        wdata      = 8'h00;
        raddr_a    = 4'd0;
        raddr_b    = 4'd9;
        clr_start  = 1'b0;
        repeat (3) tick();
        check_val("rst_held_rdata_a", {24'd0, rdata_a}, 32'h0);
        check_val("rst_held_valid_b", {31'd0, valid_b}, 32'h0);
        reset = 1'b1;
        tick();

        // Reset state
        check_val("rst_rdata_a", {24'd0, rdata_a}, 32'h0);
        check_val("rst_rdata_b", {24'd0, rdata_b}, 32'h0);
        check_val("rst_valid_a", {31'd0, valid_a}, 32'h0);
        check_val("rst_valid_b", {31'd0, valid_b}, 32'h0);
        check_val("rst_busy",    {31'd0, busy},    32'h0);
        check_val("rst_wr_err",  {31'd0, wr_err},  32'h0);

        // Dual read
        wr(4'd2, 8'h3C);
        check_val("wr_ok_err", {31'd0, wr_err}, 32'h0);
        wr(4'd9, 8'hA5);
        raddr_a = 4'd2;
        raddr_b = 4'd9;
        #1;
        check_val("dual_rdata_a", {24'd0, rdata_a}, 32'h3C);
        check_val("dual_rdata_b", {24'd0, rdata_b}, 32'hA5);
        check_val("dual_valid_a", {31'd0, valid_a}, 32'h1);
        check_val("dual_valid_b", {31'd0, valid_b}, 32'h1);

        // Write bypass vs. next-cycle visibility
        wr(4'd5, 8'h44);
        raddr_a = 4'd5;
        we      = 1'b1;
        waddr   = 4'd5;
        wdata   = 8'h7E;
        #1;
`ifdef REGBANK_WRITE_BYPASS_EN
        check_val("byp_before_edge", {24'd0, rdata_a}, 32'h7E);
`else
        check_val("byp_before_edge", {24'd0, rdata_a}, 32'h44);
`endif
        check_val("byp_valid_before", {31'd0, valid_a}, 32'h1);
        tick();
        we = 1'b0;
        #1;
        check_val("byp_after_edge", {24'd0, rdata_a}, 32'h7E);

        // Out-of-range write
        wr(4'd12, 8'hFF);
        raddr_a = 4'd12;
        raddr_b = 4'd2;
        #1;
        check_val("oor_wr_err",  {31'd0, wr_err},  32'h1);
        check_val("oor_rdata_a", {24'd0, rdata_a}, 32'h0);
        check_val("oor_valid_a", {31'd0, valid_a}, 32'h0);
        check_val("oor_no_alias", {24'd0, rdata_b}, 32'h3C);
        tick();
        check_val("oor_err_one_cycle", {31'd0, wr_err}, 32'h0);

        // Fill 0..9 with 8'h11..8'h1A, then sweep
        for (int i = 0; i < 10; i++) wr(4'(i), 8'(8'h11 + i));
        clr_start = 1'b1;
        tick();
        clr_start  = 1'b0;
        busy_cnt_s = busy ? 1 : 0;
        check_val("clr_busy_rise", {31'd0, busy}, 32'h1);
        step_busy();
        step_busy();
        raddr_a = 4'd0;
        raddr_b = 4'd5;
        #1;
        check_val("clr_addr0_zero",  {24'd0, rdata_a}, 32'h0);
        check_val("clr_addr0_valid", {31'd0, valid_a}, 32'h0);
        check_val("clr_addr5_old",   {24'd0, rdata_b}, 32'h16);
        check_val("clr_addr5_valid", {31'd0, valid_b}, 32'h1);
        // Rejected mid-sweep write plus an ignored restart request
        we        = 1'b1;
        waddr     = 4'd9;
        wdata     = 8'hEE;
        clr_start = 1'b1;
        raddr_b   = 4'd9;
        step_busy();
        we        = 1'b0;
        clr_start = 1'b0;
        #1;
        check_val("clr_wr_err",    {31'd0, wr_err},  32'h1);
        check_val("clr_wr_nostore", {24'd0, rdata_b}, 32'h1A);
        guard_s = 0;
        while (busy && guard_s < 40) begin
            step_busy();
            guard_s++;
        end
        check_val("clr_busy_fall", {31'd0, busy}, 32'h0);
        check_val("clr_busy_len", 32'(busy_cnt_s), 32'd10);
        for (int i = 0; i < 10; i++) begin
            raddr_a = 4'(i);
            #1;
            check_val("clr_all_zero", {23'd0, valid_a, rdata_a}, 32'h0);
        end

        // Simultaneous write + clear start, then reset mid-sweep
        wr(4'd9, 8'h5A);
        we        = 1'b1;
        waddr     = 4'd4;
        wdata     = 8'h99;
        clr_start = 1'b1;
        tick();
        we        = 1'b0;
        clr_start = 1'b0;
        raddr_a   = 4'd4;
        raddr_b   = 4'd9;
        #1;
        check_val("simul_wr_err", {31'd0, wr_err},  32'h0);
        check_val("simul_busy",   {31'd0, busy},    32'h1);
        check_val("simul_stored", {24'd0, rdata_a}, 32'h99);
        repeat (3) tick();
        check_val("mid_busy_c4", {31'd0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check_val("mid_rst_busy",    {31'd0, busy},    32'h0);
        check_val("mid_rst_addr4",   {24'd0, rdata_a}, 32'h0);
        check_val("mid_rst_addr9",   {24'd0, rdata_b}, 32'h0);
        check_val("mid_rst_valid9",  {31'd0, valid_b}, 32'h0);
        #2;
        reset = 1'b1;
        tick();
        tick();
        check_val("mid_no_resume", {31'd0, busy}, 32'h0);
        wr(4'd3, 8'h33);
        raddr_a = 4'd3;
        #1;
        check_val("post_rst_wr_err", {31'd0, wr_err},  32'h0);
        check_val("post_rst_rdata",  {24'd0, rdata_a}, 32'h33);
        check_val("post_rst_valid",  {31'd0, valid_a}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regbank_dualrd.md
Name: regbank_dualrd

Overview:
- Parametrised successor of the calculator register bank: one write port and two independent combinational read ports, so both operands are fetched in one cycle.
- Adds per-register valid bits, out-of-range protection and a sequential clear engine that zeroes the bank one entry per clock.
- Sits between the keypad/operand controller and the ALU datapath.

Parameters:
- DATA_W, 8, register width in bits.
- DEPTH, 10, number of registers (addresses 0..DEPTH-1).
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: 0 clears all state immediately.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  DATA_W  read port A data.
- valid_a  output  1  entry at raddr_a written since last reset/clear.
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  DATA_W  read port B data.
- valid_b  output  1  entry at raddr_b written since last reset/clear.
- clr_start  input  1  request sequential clear of the whole bank.
- busy  output  1  clear engine active.
- wr_err  output  1  one-cycle pulse: previous-cycle write rejected.

Behaviour:
- Reset (reset=0, async): all registers 0, all valid bits 0, FSM=IDLE, clear counter 0, busy=0, wr_err=0. rdata_a/rdata_b read 0 and valid_a/valid_b read 0 while reset is held.
- Reads: combinational, zero latency. rdata_x = reg[raddr_x], valid_x = vld[raddr_x]. raddr_x >= DEPTH gives rdata_x=0, valid_x=0.
- Write acceptance: we=1, FSM=IDLE and waddr<DEPTH.
  - Effect on the same rising edge: reg[waddr]<=wdata, vld[waddr]<=1.
  - New value is visible on the read ports the cycle after the edge.
- Write rejection: we=1 with waddr>=DEPTH, or we=1 while FSM=CLEAR.
  - No state change.
  - wr_err=1 for exactly the next cycle (registered). Otherwise wr_err=0.
- FSM states:
  - IDLE: busy=0. clr_start=1 moves to CLEAR and loads counter=0.
  - CLEAR: busy=1. Each cycle reg[counter]<=0, vld[counter]<=0, counter++. After counter=DEPTH-1 is cleared, return to IDLE.
  - busy is registered, so it goes high the cycle after clr_start is sampled and stays high exactly DEPTH cycles.
- Simultaneous we and clr_start in IDLE: write is accepted on that edge and the clear starts; the written entry is later zeroed by the sweep.
- clr_start while in CLEAR: ignored, no restart.
- Reads during CLEAR: entries below counter read 0/valid 0; entries at or above counter still return old contents.
- Reset asserted mid-clear: immediate return to IDLE with everything zeroed; no resumption after reset is released.
- Counter width: ADDR_W bits, never exceeds DEPTH-1.

Optional Feature:
- Macro: REGBANK_WRITE_BYPASS_EN.
- Defined: write-first forwarding. When a write is accepted this cycle and raddr_x==waddr, rdata_x=wdata and valid_x=1 combinationally, before the edge. Rejected writes never forward.
- Undefined: read ports show only stored contents; new data appears the cycle after the write edge.

Test Plan:
- Reset then read: release reset, raddr_a=0, raddr_b=9 -> rdata_a=0, rdata_b=0, valid_a=0, valid_b=0, busy=0.
- Dual read: write 8'h3C to addr 2 and 8'hA5 to addr 9; raddr_a=2, raddr_b=9 next cycle -> rdata_a=3C, rdata_b=A5, valid_a=valid_b=1.
- Out-of-range: we=1, waddr=12, wdata=FF -> wr_err=1 for one cycle, no change. raddr_a=12 -> rdata_a=0, valid_a=0.
- Clear sweep: fill addrs 0..9 with 8'h11..8'h1A, pulse clr_start -> busy high exactly 10 cycles.
  - Two cycles after busy rises, addr 0 reads 0 and addr 5 still reads 16.
  - After busy falls, all entries read 0 with valid 0.
  - A write issued mid-sweep gives wr_err=1 and is not stored.
- Reset mid-clear: assert reset at cycle 4 of the sweep -> busy=0 immediately, all entries 0. After release, a write to addr 3 is accepted.
- Bypass (macro defined): we=1, waddr=raddr_a=5, wdata=7E in the same cycle -> rdata_a=7E, valid_a=1 before the edge. With the macro undefined -> old value before the edge, 7E after.
